// File: rtl/alu_share_pkg.sv
// Shared types and constants for the ALU-sharing controller.
// Holds width defaults, FSM state encoding, ALU op codes, grant helper.
package alu_share_pkg;

    localparam int DEF_W     = 5;
    localparam int DEF_SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_CMP    = 2'b00;
    localparam logic [1:0] OP_MUL_SH = 2'b01;
    localparam logic [1:0] OP_MUL_HI = 2'b10;
    localparam logic [1:0] OP_SUB    = 2'b11;

    // Requester index -> one-hot select over the two requesters.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input arbiter producing a one-hot (or zero) grant.
// Ports: valid[1:0] requests, last_grant previous winner, grant[1:0].
// Macro ALU_SHARE_RR_EN: defined -> round-robin on ties,
// undefined -> requester 0 always wins ties.
import alu_share_pkg::*;

module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    logic [1:0] tie;

`ifdef ALU_SHARE_RR_EN
    // Favour whoever did not win last time.
    assign tie = onehot2(~last_grant);
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign tie = 2'b01;
`endif

    always_comb begin
        grant = 2'b00;
        unique case (1'b1)
            (valid == 2'b11): grant = tie;
            (valid == 2'b01): grant = 2'b01;
            (valid == 2'b10): grant = 2'b10;
            default:          grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two valid/ready requesters.
// Ports: clk, rst (sync, active high); req_valid/req_ready and
// per-requester x/y/s/cin; rsp_valid pulse with rsp_f/rsp_cout;
// registered alu_x/alu_y/alu_s/alu_cin out, alu_f/alu_cout in; busy.
// Macro ALU_SHARE_RR_EN (in rr_arb2) selects round-robin ties.
import alu_share_pkg::*;

module alu_share_ctrl #(
    parameter int W     = DEF_W,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [W-1:0]     req0_x,
    input  logic [W-1:0]     req0_y,
    input  logic [SEL_W-1:0] req0_s,
    input  logic             req0_cin,
    input  logic [W-1:0]     req1_x,
    input  logic [W-1:0]     req1_y,
    input  logic [SEL_W-1:0] req1_s,
    input  logic             req1_cin,
    output logic [1:0]       rsp_valid,
    output logic [W-1:0]     rsp_f,
    output logic             rsp_cout,
    output logic [W-1:0]     alu_x,
    output logic [W-1:0]     alu_y,
    output logic [SEL_W-1:0] alu_s,
    output logic             alu_cin,
    input  logic [W-1:0]     alu_f,
    input  logic             alu_cout,
    output logic             busy
);

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic       owner;
    logic [1:0] grant;
    logic       accept;
    logic       win;

    rr_arb2 u_arb (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign accept = |(req_valid & req_ready);
    assign win    = req_ready[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = grant;
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = onehot2(owner);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operands change only on accept so the ALU sees a stable input
    // for the whole EXEC cycle; the result is captured at its end.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_x      <= '0;
            alu_y      <= '0;
            alu_s      <= '0;
            alu_cin    <= 1'b0;
            rsp_f      <= '0;
            rsp_cout   <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                alu_x      <= win ? req1_x : req0_x;
                alu_y      <= win ? req1_y : req0_y;
                alu_s      <= win ? req1_s : req0_s;
                alu_cin    <= win ? req1_cin : req0_cin;
                owner      <= win;
                last_grant <= win;
            end
            if (state == EXEC) begin
                rsp_f    <= alu_f;
                rsp_cout <= alu_cout;
            end
        end
    end

endmodule
